vec_result_collector: RTL and testbench

Receive-side companion of `vec_alu_wrapper`. It captures the per-lane result chunks (`vdN`, `regiN`, `doneN`) produced by up to four vector ALU lanes and assembles them into one VLEN-bit destination vector. Once every active lane has signalled done, it presents the vector to register-file writeback over a valid/ready handshake. It sits between the lane wrapper and the vector register file write port.

---
 rtl/vec_result_collector.sv | 162 ++++++++++++++++
 tb/tb_vec_result_collector.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_result_collector.sv
// Collects per-lane ALU result chunks into one VLEN-bit vector and hands it to writeback.
// Optional VEC_COLLECT_PRELOAD_EN: adds vd_old and seeds the accumulator from it on start.
module vec_result_collector #(
    parameter int         VLEN       = 128,
    parameter logic [2:0] LANE_WIDTH = 3'b100
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      vsew,
    input  logic [1:0]      nb_lanes,
    input  logic [3:0]      lane_valid,
    input  logic [63:0]     vd0,
    input  logic [63:0]     vd1,
    input  logic [63:0]     vd2,
    input  logic [63:0]     vd3,
    input  logic [9:0]      regi0,
    input  logic [9:0]      regi1,
    input  logic [9:0]      regi2,
    input  logic [9:0]      regi3,
    input  logic            done0,
    input  logic            done1,
    input  logic            done2,
    input  logic            done3,
`ifdef VEC_COLLECT_PRELOAD_EN
    input  logic [VLEN-1:0] vd_old,
`endif
    input  logic            out_ready,
    output logic            out_valid,
    output logic [VLEN-1:0] out_vd,
    output logic            busy,
    output logic            err
);

    localparam int IDXW   = $clog2(VLEN);
    localparam int LANE_W = 1 << LANE_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [VLEN-1:0] acc_q, acc_d;
    logic [3:0]      df_q, df_d;
    logic            err_q, err_d;
    logic [2:0]      vsew_q, vsew_d;
    logic [1:0]      nbl_q, nbl_d;

    logic [63:0]     vd_a   [4];
    logic [9:0]      regi_a [4];
    logic [3:0]      done_v;
    logic [3:0]      lane_act;
    logic [VLEN-1:0] acc_init;
    logic            restart;
    int              elem_w;
    int              chunk_w;

    assign vd_a[0]   = vd0;
    assign vd_a[1]   = vd1;
    assign vd_a[2]   = vd2;
    assign vd_a[3]   = vd3;
    assign regi_a[0] = regi0;
    assign regi_a[1] = regi1;
    assign regi_a[2] = regi2;
    assign regi_a[3] = regi3;
    assign done_v    = {done3, done2, done1, done0};

`ifdef VEC_COLLECT_PRELOAD_EN
    assign acc_init = vd_old;
`else
    assign acc_init = '0;
`endif

    // nb_lanes is a log2 count; 2 and 3 both mean all four lanes.
    assign lane_act = (nbl_q == 2'd0) ? 4'b0001 :
                      (nbl_q == 2'd1) ? 4'b0011 : 4'b1111;

    always_comb begin
        elem_w  = int'(32'd8 << vsew_q[1:0]);
        chunk_w = (elem_w < LANE_W) ? elem_w : LANE_W;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            df_q    <= '0;
            err_q   <= 1'b0;
            vsew_q  <= '0;
            nbl_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            df_q    <= df_d;
            err_q   <= err_d;
            vsew_q  <= vsew_d;
            nbl_q   <= nbl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        df_d    = df_q;
        err_d   = err_q;
        vsew_d  = vsew_q;
        nbl_d   = nbl_q;
        restart = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) restart = 1'b1;
            end
            S_COLLECT: begin
                if (start) begin
                    restart = 1'b1;
                end else begin
                    // Ascending lane order lets the higher lane win on overlap.
                    for (int l = 0; l < 4; l++) begin
                        if (lane_act[l] && lane_valid[l] && !vsew_q[2]) begin
                            if (int'(regi_a[l]) + chunk_w > VLEN) begin
                                err_d = 1'b1;
                            end else begin
                                for (int b = 0; b < 64; b++) begin
                                    if (b < chunk_w)
                                        acc_d[IDXW'(int'(regi_a[l]) + b)] = vd_a[l][6'(b)];
                                end
                            end
                        end
                    end
                    if (vsew_q[2]) err_d = 1'b1;
                    df_d = df_q | (done_v & lane_act);
                    if ((df_d & lane_act) == lane_act) state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (start) restart = 1'b1;
                    else       state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            state_d = S_COLLECT;
            acc_d   = acc_init;
            df_d    = '0;
            err_d   = 1'b0;
            vsew_d  = vsew;
            nbl_d   = nb_lanes;
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign out_vd    = acc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vec_result_collector.sv
// Randomized self-checking bench for vec_result_collector against a chunk-level model.
module tb_vec_result_collector;

    localparam logic [127:0] VEC1 = 128'h3232eeeed0231467d02314673232eeee;
    localparam logic [127:0] VEC2 = 128'h3332eeeed1241567d12415673332eeee;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   vsew = '0;
    logic [1:0]   nb_lanes = '0;
    logic [3:0]   lane_valid = '0;
    logic [63:0]  tb_vd [4];
    logic [9:0]   tb_regi [4];
    logic [3:0]   tb_done = '0;
    logic         out_ready = 1'b0;
    logic [127:0] vd_old = '0;
    logic         out_valid;
    logic [127:0] out_vd;
    logic         busy;
    logic         err;

    logic [63:0]  vd0, vd1, vd2, vd3;
    logic [9:0]   regi0, regi1, regi2, regi3;
    assign vd0 = tb_vd[0];
    assign vd1 = tb_vd[1];
    assign vd2 = tb_vd[2];
    assign vd3 = tb_vd[3];
    assign regi0 = tb_regi[0];
    assign regi1 = tb_regi[1];
    assign regi2 = tb_regi[2];
    assign regi3 = tb_regi[3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [127:0] m_acc;
    bit           m_err;
    bit [3:0]     m_df;
    bit [3:0]     m_act;
    bit           m_res;
    int           m_w;

    always #5 clk = ~clk;

    vec_result_collector dut (
        .clk(clk), .resetn(resetn), .start(start), .vsew(vsew), .nb_lanes(nb_lanes),
        .lane_valid(lane_valid),
        .vd0(vd0), .vd1(vd1), .vd2(vd2), .vd3(vd3),
        .regi0(regi0), .regi1(regi1), .regi2(regi2), .regi3(regi3),
        .done0(tb_done[0]), .done1(tb_done[1]), .done2(tb_done[2]), .done3(tb_done[3]),
`ifdef VEC_COLLECT_PRELOAD_EN
        .vd_old(vd_old),
`endif
        .out_ready(out_ready), .out_valid(out_valid), .out_vd(out_vd),
        .busy(busy), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        lane_valid = '0;
        tb_done    = '0;
        for (int l = 0; l < 4; l++) begin
            tb_vd[l]   = {$urandom, $urandom};
            tb_regi[l] = 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic m_start(input logic [2:0] v, input logic [1:0] n);
        int e;
`ifdef VEC_COLLECT_PRELOAD_EN
        m_acc = vd_old;
`else
        m_acc = '0;
`endif
        m_err = 0;
        m_df  = '0;
        e     = 8 << v[1:0];
        m_w   = (e < 16) ? e : 16;
        m_res = v[2];
        m_act = (n == 0) ? 4'b0001 : (n == 1) ? 4'b0011 : 4'b1111;
    endtask

    // Applies the current cycle's lane inputs to the model; reports completion.
    task automatic m_cycle(output bit complete);
        logic [6:0] ix;
        for (int l = 0; l < 4; l++) begin
            if (m_act[l] && lane_valid[l] && !m_res) begin
                if (int'(tb_regi[l]) + m_w > 128) begin
                    m_err = 1;
                end else begin
                    for (int b = 0; b < m_w; b++) begin
                        ix = 7'(int'(tb_regi[l]) + b);
                        m_acc[ix] = tb_vd[l][6'(b)];
                    end
                end
            end
        end
        if (m_res) m_err = 1;
        m_df = m_df | (tb_done & m_act);
        complete = ((m_df & m_act) == m_act);
    endtask

    task automatic do_start(input logic [2:0] v, input logic [1:0] n);
        vd_old   = {$urandom, $urandom, $urandom, $urandom};
        start    = 1'b1;
        vsew     = v;
        nb_lanes = n;
        m_start(v, n);
        tick();
        start = 1'b0;
        vsew  = 3'($urandom);
        nb_lanes = 2'($urandom);
    endtask

    task automatic test_reset();
        bit c;
        resetn = 1'b0;
        clear_lanes();
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || out_vd !== '0) begin
            n_fail++;
            $display("FAIL reset_init: out_valid=%b busy=%b err=%b out_vd=%h required 0 0 0 0", out_valid, busy, err, out_vd);
        end
        resetn = 1'b1;
        tick();
        do_start(3'd0, 2'd0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: busy=%b required 1", busy);
        end
        lane_valid = 4'b0001; tb_regi[0] = 10'd0; tb_vd[0] = 64'hAB;
        m_cycle(c);
        tick();
        tb_regi[0] = 10'd124;
        m_cycle(c);
        tick();
        clear_lanes();
        n_checks++;
        if (err !== 1'b1 || out_vd !== m_acc) begin
            n_fail++;
            $display("FAIL pre_reset_state: err=%b out_vd=%h required 1 %h", err, out_vd, m_acc);
        end
        #3;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || out_vd !== '0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b busy=%b err=%b out_vd=%h required 0 0 0 0", out_valid, busy, err, out_vd);
        end
        #1;
        resetn = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_lane();
        bit c;
        logic [127:0] ref_v;
        ref_v = VEC1;
        do_start(3'd0, 2'd0);
        for (int k = 0; k < 16; k++) begin
            lane_valid = 4'b0001;
            tb_regi[0] = 10'(8 * k);
            tb_vd[0]   = {$urandom, 24'($urandom), ref_v[8*k +: 8]};
            tb_done    = (k == 15) ? 4'b0001 : 4'b0000;
            m_cycle(c);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_early_valid[%0d]: out_valid=%b required 0", k, out_valid);
            end
            tick();
        end
        clear_lanes();
        n_checks++;
        if (out_valid !== 1'b1 || out_vd !== VEC1) begin
            n_fail++;
            $display("FAIL single_result: out_valid=%b out_vd=%h required 1 %h", out_valid, out_vd, VEC1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_handshake: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        $display("test_single_lane done");
    endtask

    task automatic test_four_lanes();
        bit c;
        logic [127:0] ref_v;
        ref_v = VEC2;
        do_start(3'd2, 2'd2);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            lane_valid = '0;
            tb_done    = '0;
            for (int i = 0; i < 4; i++) begin
                int j;
                j = (cyc == 1) ? 0 : 1;
                if (cyc == 1 || (cyc == 2 && i < 3) || (cyc == 3 && i == 3)) begin
                    lane_valid[i] = 1'b1;
                    tb_regi[i]    = 10'(16 * (j * 4 + i));
                    tb_vd[i]      = {$urandom, 16'($urandom), ref_v[16*(j*4+i) +: 16]};
                    tb_done[i]    = (j == 1);
                end
            end
            m_cycle(c);
            tick();
            n_checks++;
            if (out_valid !== (cyc == 3)) begin
                n_fail++;
                $display("FAIL four_valid_cycle%0d: out_valid=%b required %b", cyc, out_valid, cyc == 3);
            end
        end
        clear_lanes();
        n_checks++;
        if (out_vd !== VEC2) begin
            n_fail++;
            $display("FAIL four_result: out_vd=%h required %h", out_vd, VEC2);
        end
        $display("test_four_lanes done");
    endtask

    // Entered with the DUT holding a completed vector in OUT.
    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            vsew  = 3'd0;
            nb_lanes = 2'd0;
            lane_valid = 4'b1111;
            tick();
            start = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || out_vd !== m_acc || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: out_valid=%b busy=%b out_vd=%h required 1 1 %h", k, out_valid, busy, out_vd, m_acc);
            end
        end
        clear_lanes();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_out_of_range();
        bit c;
        do_start(3'd1, 2'd0);
        lane_valid = 4'b0001; tb_regi[0] = 10'd112; tb_vd[0] = {$urandom, $urandom};
        m_cycle(c);
        tick();
        tb_regi[0] = 10'd120; tb_vd[0] = {$urandom, $urandom}; tb_done = 4'b0001;
        m_cycle(c);
        tick();
        clear_lanes();
        n_checks++;
        if (out_valid !== 1'b1 || err !== 1'b1 || out_vd[127:120] !== m_acc[127:120]) begin
            n_fail++;
            $display("FAIL oor_drop: out_valid=%b err=%b top=%h required 1 1 %h", out_valid, err, out_vd[127:120], m_acc[127:120]);
        end
        n_checks++;
        if (out_vd !== m_acc) begin
            n_fail++;
            $display("FAIL oor_vector: out_vd=%h required %h", out_vd, m_acc);
        end
        // back-to-back: accept and restart in the same edge
        out_ready = 1'b1;
        do_start(3'd0, 2'd1);
        out_ready = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: err=%b busy=%b out_valid=%b required 0 1 0", err, busy, out_valid);
        end
        lane_valid = 4'b0011; tb_regi[0] = 10'd40; tb_regi[1] = 10'd44;
        tb_done = 4'b0011;
        m_cycle(c);
        tick();
        clear_lanes();
        n_checks++;
        if (out_valid !== 1'b1 || out_vd !== m_acc || err !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_result: out_valid=%b err=%b out_vd=%h required 1 0 %h", out_valid, err, out_vd, m_acc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("test_out_of_range done");
    endtask

    task automatic test_restart();
        bit c;
        logic [127:0] ref_v;
        ref_v = VEC1;
        do_start(3'd0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            lane_valid = 4'b0001; tb_regi[0] = 10'(8 * k); tb_vd[0] = {$urandom, $urandom};
            m_cycle(c);
            tick();
        end
        // restart cycle carries a chunk that must be discarded
        lane_valid = 4'b0001; tb_regi[0] = 10'd0; tb_vd[0] = 64'hFF;
        do_start(3'd0, 2'd0);
        for (int k = 1; k < 16; k++) begin
            lane_valid = 4'b0001;
            tb_regi[0] = 10'(8 * k);
            tb_vd[0]   = {56'($urandom), ref_v[8*k +: 8]};
            tb_done    = (k == 15) ? 4'b0001 : 4'b0000;
            m_cycle(c);
            tick();
        end
        clear_lanes();
        n_checks++;
        if (out_valid !== 1'b1 || out_vd !== m_acc) begin
            n_fail++;
            $display("FAIL restart_result: out_valid=%b out_vd=%h required 1 %h", out_valid, out_vd, m_acc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("test_restart done");
    endtask

    task automatic test_random();
        bit c;
        int cyc;
        for (int t = 0; t < 40; t++) begin
            do_start(3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
            c   = 0;
            cyc = 0;
            while (!c && cyc < 20) begin
                lane_valid = 4'($urandom);
                for (int l = 0; l < 4; l++) begin
                    tb_vd[l]   = {$urandom, $urandom};
                    tb_regi[l] = 10'($urandom_range(0, 135));
                end
                tb_done = (cyc == 19) ? 4'b1111 : 4'(($urandom_range(0, 3) == 0) ? $urandom : 0);
                m_cycle(c);
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_early_valid[%0d]: out_valid=%b required 0", t, out_valid);
                end
                tick();
                cyc++;
            end
            clear_lanes();
            n_checks++;
            if (out_valid !== 1'b1 || out_vd !== m_acc || err !== m_err) begin
                n_fail++;
                $display("FAIL rand_result[%0d]: out_valid=%b err=%b out_vd=%h required 1 %b %h", t, out_valid, err, out_vd, m_err, m_acc);
            end
            repeat ($urandom_range(0, 2)) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_handshake[%0d]: out_valid=%b busy=%b required 0 0", t, out_valid, busy);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_four_lanes();
        test_backpressure();
        test_out_of_range();
        test_restart();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
